riscv_multicycle_controller: RTL and testbench
==============================================

Name:
riscv_multicycle_controller

Overview:
- FSM-based control unit for the multi-cycle RISC-V datapath. It succeeds the single-cycle controller.
- Decodes op/func3/func7 once per instruction and sequences fetch, decode, execute, memory and writeback over several cycles.
- Has a memory-ready handshake, an optional LUI path, illegal-opcode trapping and an instruction-retire pulse.
- Sits between the instruction register and the shared-memory datapath.

Parameters:
- SUPPORT_LUI, 1: 1 = decode LUI (0110111); 0 = treat it as illegal.
- TRAP_ON_ILLEGAL, 1: 1 = illegal opcode enters TRAP; 0 = return to FETCH (NOP).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- op  in  7  instruction[6:0], valid from DECODE onward
- func3  in  3  instruction[14:12]
- func7  in  1  instruction[30]
- zero  in  1  ALU result == 0 (combinational)
- neg  in  1  ALU result sign (combinational)
- mem_ready  in  1  memory completes the current access this cycle
- PCWrite  out  1  PC register enable
- adrSrc  out  1  memory address: 0 = PC, 1 = ALUOut
- memWrite  out  1  data memory write
- IRWrite  out  1  instruction and oldPC register enable
- regWrite  out  1  register file write
- resultSrc  out  2  00 = ALUOut, 01 = memData, 10 = ALUResult, 11 = imm
- ALUSrcA  out  2  00 = PC, 01 = oldPC, 10 = rs1
- ALUSrcB  out  2  00 = rs2, 01 = imm, 10 = const 4
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 sltu
- immSrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U
- instr_done  out  1  one-cycle pulse in the final state of each instruction
- illegal  out  1  high while in TRAP
- state  out  4  current state, for debug

Behaviour:
- Reset: state = FETCH next cycle. All enables, instr_done and illegal are 0. Selects are 0 except in FETCH.
- Outputs are Moore functions of state. Exceptions:
  - PCWrite/IRWrite in FETCH are gated by mem_ready.
  - PCWrite in BRANCH is gated by the branch condition.
  - ALUControl in EXEC_R/EXEC_I depends on func3/func7.
- Unlisted outputs are 0 in every state.
- FETCH (0):
  - adrSrc=0; A=00; B=10; add; resultSrc=10.
  - IRWrite=PCWrite=mem_ready.
  - Stay in FETCH while !mem_ready; else go to DECODE.
- DECODE (1):
  - A=01; B=01; add (ALUOut <= oldPC+imm).
  - immSrc=010 (B) for branch, 011 for jal; 000 otherwise.
  - Dispatch on op:
    - 0110011 → EXEC_R
    - 0010011 → EXEC_I
    - 0000011 / 0100011 → MEM_ADR
    - 1100011 → BRANCH
    - 1101111 → JAL
    - 1100111 → JALR_ADR
    - 0110111 → LUI (if SUPPORT_LUI)
    - anything else → TRAP or FETCH, per TRAP_ON_ILLEGAL
- EXEC_R (2): A=10, B=00 → ALU_WB.
- EXEC_I (3): A=10, B=01, immSrc=000 → ALU_WB.
- ALU op in EXEC_R/EXEC_I by func3:
  - 000: sub only when R-type and func7=1; otherwise add. I-type never subtracts.
  - 111 and; 110 or; 100 xor; 010 slt; 011 sltu.
  - 001/101: add.
- ALU_WB (4): resultSrc=00, regWrite=1, instr_done=1 → FETCH.
- MEM_ADR (5):
  - A=10, B=01, add.
  - immSrc=001 if op=0100011, else 000.
  - → MEM_RD (load) or MEM_WR (store).
- MEM_RD (6): adrSrc=1. Hold until mem_ready, then → MEM_WB.
- MEM_WB (7): resultSrc=01, regWrite=1, instr_done=1 → FETCH.
- MEM_WR (8):
  - adrSrc=1, memWrite=1, held every cycle until mem_ready.
  - When mem_ready: instr_done=1, → FETCH.
- BRANCH (9):
  - A=10, B=00, sub, resultSrc=00, immSrc=010, instr_done=1 → FETCH.
  - PCWrite by func3: 000 → zero; 001 → !zero; 100 → neg; 101 → !neg; any other → 0 (not taken, no trap).
- JAL (10): A=01, B=10, add, resultSrc=00, PCWrite=1 → ALU_WB (writes oldPC+4).
- JALR_ADR (11): A=10, B=01, immSrc=000, add → JALR.
- JALR (12):
  - A=01, B=10, add, resultSrc=00, PCWrite=1 → ALU_WB.
  - Target bit 0 is not cleared.
- LUI (13): resultSrc=11, immSrc=100, regWrite=1, instr_done=1 → FETCH.
- TRAP (14): illegal=1; all enables 0; stays until rst.
- Encoding 15 is unreachable; if entered, go to FETCH.
- rst in any state, including mid-wait in MEM_RD/MEM_WR or in TRAP, returns to FETCH next cycle with all enables deasserted in that cycle.
- Cycles per instruction with mem_ready always 1:
  - R/I/jal/jalr: 4 (jalr: 5)
  - lw: 5; sw: 4; branch: 3; lui: 3
- Each wait cycle adds one cycle.

Test Plan:
- rst held 2 cycles with mem_ready=1 → after release, state=0, IRWrite=PCWrite=1; next state=1.
- R-type op=0110011, func3=000, func7=1 → EXEC_R ALUControl=001. Then ALU_WB regWrite=1, instr_done=1; 4 cycles total.
- lw with mem_ready low 3 cycles in MEM_RD → adrSrc=1 held for 4 cycles. Then MEM_WB resultSrc=01, regWrite=1; 8 cycles total.
- beq with zero=1 → PCWrite=1 in BRANCH; same instruction with zero=0 → PCWrite=0; both 3 cycles. bge with neg=0 → taken.
- jal → JAL PCWrite=1, A=01, B=10; then ALU_WB regWrite=1. jalr visits state 11 then 12.
- op=1111111 with TRAP_ON_ILLEGAL=1 → state 14, illegal=1, no enables for 10 cycles; rst → FETCH. With TRAP_ON_ILLEGAL=0 → FETCH directly. With SUPPORT_LUI=0, LUI → trap.

Source files
------------

// File: rtl/riscv_multicycle_controller.sv
// Multi-cycle RISC-V control FSM: sequences fetch/decode/execute/memory/writeback
// with a memory-ready handshake, optional LUI, illegal-opcode trap and retire pulse.
module riscv_multicycle_controller #(
    parameter bit SUPPORT_LUI     = 1'b1,
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] func3,
    input  logic       func7,
    input  logic       zero,
    input  logic       neg,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       adrSrc,
    output logic       memWrite,
    output logic       IRWrite,
    output logic       regWrite,
    output logic [1:0] resultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [2:0] immSrc,
    output logic       instr_done,
    output logic       illegal,
    output logic [3:0] state
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_EXEC_R   = 4'd2;
    localparam logic [3:0] S_EXEC_I   = 4'd3;
    localparam logic [3:0] S_ALU_WB   = 4'd4;
    localparam logic [3:0] S_MEM_ADR  = 4'd5;
    localparam logic [3:0] S_MEM_RD   = 4'd6;
    localparam logic [3:0] S_MEM_WB   = 4'd7;
    localparam logic [3:0] S_MEM_WR   = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;
    localparam logic [3:0] S_JALR_ADR = 4'd11;
    localparam logic [3:0] S_JALR     = 4'd12;
    localparam logic [3:0] S_LUI      = 4'd13;
    localparam logic [3:0] S_TRAP     = 4'd14;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_SLT  = 3'b101;
    localparam logic [2:0] ALU_SLTU = 3'b110;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [3:0] S_ILLEGAL = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;

    // ALU operation select for EXEC_R/EXEC_I; func3 001/101 map to add.
    function automatic logic [2:0] alu_dec(input logic [2:0] f3, input logic f7, input logic is_r);
        case (f3)
            3'b000:  alu_dec = (is_r && f7) ? ALU_SUB : ALU_ADD;
            3'b111:  alu_dec = ALU_AND;
            3'b110:  alu_dec = ALU_OR;
            3'b100:  alu_dec = ALU_XOR;
            3'b010:  alu_dec = ALU_SLT;
            3'b011:  alu_dec = ALU_SLTU;
            default: alu_dec = ALU_ADD;
        endcase
    endfunction

    function automatic logic br_taken(input logic [2:0] f3, input logic z, input logic n);
        case (f3)
            3'b000:  br_taken = z;
            3'b001:  br_taken = !z;
            3'b100:  br_taken = n;
            3'b101:  br_taken = !n;
            default: br_taken = 1'b0;
        endcase
    endfunction

    logic [3:0] next_state;

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_FETCH;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_FETCH:    if (mem_ready) next_state = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_R:         next_state = S_EXEC_R;
                    OP_I:         next_state = S_EXEC_I;
                    OP_LW, OP_SW: next_state = S_MEM_ADR;
                    OP_BR:        next_state = S_BRANCH;
                    OP_JAL:       next_state = S_JAL;
                    OP_JALR:      next_state = S_JALR_ADR;
                    OP_LUI:       next_state = SUPPORT_LUI ? S_LUI : S_ILLEGAL;
                    default:      next_state = S_ILLEGAL;
                endcase
            end
            S_EXEC_R:   next_state = S_ALU_WB;
            S_EXEC_I:   next_state = S_ALU_WB;
            S_ALU_WB:   next_state = S_FETCH;
            S_MEM_ADR:  next_state = (op == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   if (mem_ready) next_state = S_MEM_WB;
            S_MEM_WB:   next_state = S_FETCH;
            S_MEM_WR:   if (mem_ready) next_state = S_FETCH;
            S_BRANCH:   next_state = S_FETCH;
            S_JAL:      next_state = S_ALU_WB;
            S_JALR_ADR: next_state = S_JALR;
            S_JALR:     next_state = S_ALU_WB;
            S_LUI:      next_state = S_FETCH;
            S_TRAP:     next_state = S_TRAP;
            default:    next_state = S_FETCH;
        endcase
    end

    // Outputs are forced idle while rst is high so no write escapes in the reset cycle.
    always_comb begin
        PCWrite    = 1'b0;
        adrSrc     = 1'b0;
        memWrite   = 1'b0;
        IRWrite    = 1'b0;
        regWrite   = 1'b0;
        resultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ALUControl = ALU_ADD;
        immSrc     = IMM_I;
        instr_done = 1'b0;
        illegal    = 1'b0;
        if (!rst) begin
            case (state)
                S_FETCH: begin
                    ALUSrcB   = 2'b10;
                    resultSrc = 2'b10;
                    IRWrite   = mem_ready;
                    PCWrite   = mem_ready;
                end
                S_DECODE: begin
                    ALUSrcA = 2'b01;
                    ALUSrcB = 2'b01;
                    if (op == OP_BR)
                        immSrc = IMM_B;
                    else if (op == OP_JAL)
                        immSrc = IMM_J;
                end
                S_EXEC_R: begin
                    ALUSrcA    = 2'b10;
                    ALUControl = alu_dec(func3, func7, 1'b1);
                end
                S_EXEC_I: begin
                    ALUSrcA    = 2'b10;
                    ALUSrcB    = 2'b01;
                    ALUControl = alu_dec(func3, func7, 1'b0);
                end
                S_ALU_WB: begin
                    regWrite   = 1'b1;
                    instr_done = 1'b1;
                end
                S_MEM_ADR: begin
                    ALUSrcA = 2'b10;
                    ALUSrcB = 2'b01;
                    immSrc  = (op == OP_SW) ? IMM_S : IMM_I;
                end
                S_MEM_RD: adrSrc = 1'b1;
                S_MEM_WB: begin
                    resultSrc  = 2'b01;
                    regWrite   = 1'b1;
                    instr_done = 1'b1;
                end
                S_MEM_WR: begin
                    adrSrc     = 1'b1;
                    memWrite   = 1'b1;
                    instr_done = mem_ready;
                end
                S_BRANCH: begin
                    ALUSrcA    = 2'b10;
                    ALUControl = ALU_SUB;
                    immSrc     = IMM_B;
                    instr_done = 1'b1;
                    PCWrite    = br_taken(func3, zero, neg);
                end
                S_JAL, S_JALR: begin
                    ALUSrcA = 2'b01;
                    ALUSrcB = 2'b10;
                    PCWrite = 1'b1;
                end
                S_JALR_ADR: begin
                    ALUSrcA = 2'b10;
                    ALUSrcB = 2'b01;
                end
                S_LUI: begin
                    resultSrc  = 2'b11;
                    immSrc     = IMM_U;
                    regWrite   = 1'b1;
                    instr_done = 1'b1;
                end
                S_TRAP:  illegal = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_multicycle_controller.sv
// Directed bench for riscv_multicycle_controller: per-cycle vector table plus
// hand sequences for trap, parameter variants and reset during a memory wait.
module tb_riscv_multicycle_controller;

    localparam int OPR = 'h33, OPI = 'h13, OLW = 'h03, OSW = 'h23, OBR = 'h63;
    localparam int OJAL = 'h6F, OJALR = 'h67, OLUI = 'h37, OBAD = 'h7F;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [6:0] op = 7'd0;
    logic [2:0] func3 = 3'd0;
    logic func7 = 1'b0, zero = 1'b0, neg = 1'b0, mem_ready = 1'b1;

    logic PCWrite, adrSrc, memWrite, IRWrite, regWrite, instr_done, illegal;
    logic [1:0] resultSrc, ALUSrcA, ALUSrcB;
    logic [2:0] ALUControl, immSrc;
    logic [3:0] state;

    logic nt_pcw, nt_adr, nt_mw, nt_irw, nt_rw, nt_done, nt_ill;
    logic [1:0] nt_rs, nt_a, nt_b;
    logic [2:0] nt_alu, nt_imm;
    logic [3:0] nt_state;

    logic nl_pcw, nl_adr, nl_mw, nl_irw, nl_rw, nl_done, nl_ill;
    logic [1:0] nl_rs, nl_a, nl_b;
    logic [2:0] nl_alu, nl_imm;
    logic [3:0] nl_state;

    logic [18:0] outs, nt_outs, nl_outs;
    assign outs = {PCWrite, adrSrc, memWrite, IRWrite, regWrite, resultSrc, ALUSrcA, ALUSrcB,
                   ALUControl, immSrc, instr_done, illegal};
    assign nt_outs = {nt_pcw, nt_adr, nt_mw, nt_irw, nt_rw, nt_rs, nt_a, nt_b, nt_alu, nt_imm, nt_done, nt_ill};
    assign nl_outs = {nl_pcw, nl_adr, nl_mw, nl_irw, nl_rw, nl_rs, nl_a, nl_b, nl_alu, nl_imm, nl_done, nl_ill};

    always #5 clk = ~clk;

    riscv_multicycle_controller dut (
        .clk(clk), .rst(rst), .op(op), .func3(func3), .func7(func7), .zero(zero), .neg(neg),
        .mem_ready(mem_ready), .PCWrite(PCWrite), .adrSrc(adrSrc), .memWrite(memWrite),
        .IRWrite(IRWrite), .regWrite(regWrite), .resultSrc(resultSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .immSrc(immSrc), .instr_done(instr_done),
        .illegal(illegal), .state(state)
    );

    riscv_multicycle_controller #(.SUPPORT_LUI(1'b1), .TRAP_ON_ILLEGAL(1'b0)) dut_nt (
        .clk(clk), .rst(rst), .op(op), .func3(func3), .func7(func7), .zero(zero), .neg(neg),
        .mem_ready(mem_ready), .PCWrite(nt_pcw), .adrSrc(nt_adr), .memWrite(nt_mw),
        .IRWrite(nt_irw), .regWrite(nt_rw), .resultSrc(nt_rs), .ALUSrcA(nt_a),
        .ALUSrcB(nt_b), .ALUControl(nt_alu), .immSrc(nt_imm), .instr_done(nt_done),
        .illegal(nt_ill), .state(nt_state)
    );

    riscv_multicycle_controller #(.SUPPORT_LUI(1'b0), .TRAP_ON_ILLEGAL(1'b1)) dut_nl (
        .clk(clk), .rst(rst), .op(op), .func3(func3), .func7(func7), .zero(zero), .neg(neg),
        .mem_ready(mem_ready), .PCWrite(nl_pcw), .adrSrc(nl_adr), .memWrite(nl_mw),
        .IRWrite(nl_irw), .regWrite(nl_rw), .resultSrc(nl_rs), .ALUSrcA(nl_a),
        .ALUSrcB(nl_b), .ALUControl(nl_alu), .immSrc(nl_imm), .instr_done(nl_done),
        .illegal(nl_ill), .state(nl_state)
    );

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7, z, n, rdy;
        logic [3:0]  st;
        logic [18:0] outs;
    } vec_t;

    vec_t tbl[$];
    int n_cmp = 0;
    int n_fail = 0;

    // {op, func3, func7, expected ALUControl in the execute state}
    int alu_tab [8][4] = '{
        '{OPR, 0, 1, 1}, '{OPI, 0, 1, 0}, '{OPR, 7, 0, 2}, '{OPI, 6, 0, 3},
        '{OPR, 4, 0, 4}, '{OPI, 2, 0, 5}, '{OPR, 3, 0, 6}, '{OPR, 5, 1, 0}
    };

    function automatic logic [18:0] pk(int pcw, int adr, int mw, int irw, int rw, int rs,
                                       int a, int b, int alu, int imm, int done, int ill);
        return 19'((pcw << 18) | (adr << 17) | (mw << 16) | (irw << 15) | (rw << 14) | (rs << 12) |
                   (a << 10) | (b << 8) | (alu << 5) | (imm << 2) | (done << 1) | ill);
    endfunction

    function automatic void add(int o, int f3, int f7, int z, int n, int rdy, int st,
                                int pcw, int adr, int mw, int irw, int rw, int rs,
                                int a, int b, int alu, int imm, int done, int ill);
        vec_t v;
        v.op = 7'(o); v.f3 = 3'(f3); v.f7 = 1'(f7); v.z = 1'(z); v.n = 1'(n); v.rdy = 1'(rdy);
        v.st = 4'(st);
        v.outs = pk(pcw, adr, mw, irw, rw, rs, a, b, alu, imm, done, ill);
        tbl.push_back(v);
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_state", 0, 32'(state), 32'd0);
        chk("rst_outs", 0, 32'(outs), 32'd0);
        chk("rst_nl_outs", 0, 32'(nl_outs), 32'd0);
        rst = 1'b0;
    endtask

    initial begin
        // ALU decode: fetch, decode, execute, writeback for each func3/func7 case
        foreach (alu_tab[k]) begin
            int o, f3, f7;
            o = alu_tab[k][0]; f3 = alu_tab[k][1]; f7 = alu_tab[k][2];
            add(o, f3, f7, 0, 0, 1, 0, 1, 0, 0, 1, 0, 2, 0, 2, 0, 0, 0, 0);
            add(o, f3, f7, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
            if (o == OPR)
                add(o, f3, f7, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 2, 0, alu_tab[k][3], 0, 0, 0);
            else
                add(o, f3, f7, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 2, 1, alu_tab[k][3], 0, 0, 0);
            add(o, f3, f7, 0, 0, 1, 4, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0);
        end
        // lw with three wait cycles in MEM_RD
        add(OLW, 2, 0, 0, 0, 1, 0, 1, 0, 0, 1, 0, 2, 0, 2, 0, 0, 0, 0);
        add(OLW, 2, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        add(OLW, 2, 0, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0);
        add(OLW, 2, 0, 0, 0, 0, 6, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(OLW, 2, 0, 0, 0, 0, 6, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(OLW, 2, 0, 0, 0, 0, 6, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(OLW, 2, 0, 0, 0, 1, 6, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(OLW, 2, 0, 0, 0, 1, 7, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0);
        // sw with one wait cycle in MEM_WR
        add(OSW, 2, 0, 0, 0, 1, 0, 1, 0, 0, 1, 0, 2, 0, 2, 0, 0, 0, 0);
        add(OSW, 2, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        add(OSW, 2, 0, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0, 2, 1, 0, 1, 0, 0);
        add(OSW, 2, 0, 0, 0, 0, 8, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(OSW, 2, 0, 0, 0, 1, 8, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        // beq taken after one fetch wait, then beq not taken
        add(OBR, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 2, 0, 0, 0, 0);
        add(OBR, 0, 0, 1, 0, 1, 0, 1, 0, 0, 1, 0, 2, 0, 2, 0, 0, 0, 0);
        add(OBR, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2, 0, 0);
        add(OBR, 0, 0, 1, 0, 1, 9, 1, 0, 0, 0, 0, 0, 2, 0, 1, 2, 1, 0);
        add(OBR, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1, 0, 2, 0, 2, 0, 0, 0, 0);
        add(OBR, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2, 0, 0);
        add(OBR, 0, 0, 0, 0, 1, 9, 0, 0, 0, 0, 0, 0, 2, 0, 1, 2, 1, 0);
        // bge with neg=0 taken, bne with zero=1 not taken, func3=010 never taken
        add(OBR, 5, 0, 0, 0, 1, 0, 1, 0, 0, 1, 0, 2, 0, 2, 0, 0, 0, 0);
        add(OBR, 5, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2, 0, 0);
        add(OBR, 5, 0, 0, 0, 1, 9, 1, 0, 0, 0, 0, 0, 2, 0, 1, 2, 1, 0);
        add(OBR, 1, 0, 1, 0, 1, 0, 1, 0, 0, 1, 0, 2, 0, 2, 0, 0, 0, 0);
        add(OBR, 1, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2, 0, 0);
        add(OBR, 1, 0, 1, 0, 1, 9, 0, 0, 0, 0, 0, 0, 2, 0, 1, 2, 1, 0);
        add(OBR, 2, 0, 1, 1, 1, 0, 1, 0, 0, 1, 0, 2, 0, 2, 0, 0, 0, 0);
        add(OBR, 2, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2, 0, 0);
        add(OBR, 2, 0, 1, 1, 1, 9, 0, 0, 0, 0, 0, 0, 2, 0, 1, 2, 1, 0);
        // jal, jalr, lui
        add(OJAL, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1, 0, 2, 0, 2, 0, 0, 0, 0);
        add(OJAL, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 3, 0, 0);
        add(OJAL, 0, 0, 0, 0, 1, 10, 1, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0);
        add(OJAL, 0, 0, 0, 0, 1, 4, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0);
        add(OJALR, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1, 0, 2, 0, 2, 0, 0, 0, 0);
        add(OJALR, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        add(OJALR, 0, 0, 0, 0, 1, 11, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0);
        add(OJALR, 0, 0, 0, 0, 1, 12, 1, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0);
        add(OJALR, 0, 0, 0, 0, 1, 4, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0);
        add(OLUI, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1, 0, 2, 0, 2, 0, 0, 0, 0);
        add(OLUI, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        add(OLUI, 0, 0, 0, 0, 1, 13, 0, 0, 0, 0, 1, 3, 0, 0, 0, 4, 1, 0);

        do_reset();
        foreach (tbl[i]) begin
            op = tbl[i].op; func3 = tbl[i].f3; func7 = tbl[i].f7;
            zero = tbl[i].z; neg = tbl[i].n; mem_ready = tbl[i].rdy;
            #1;
            chk("state", i, 32'(state), 32'(tbl[i].st));
            chk("outs", i, 32'(outs), 32'(tbl[i].outs));
            @(negedge clk);
        end

        // Illegal opcode: trap on dut, straight back to fetch on dut_nt, rst exits trap
        do_reset();
        op = 7'(OBAD); func3 = 3'd0; func7 = 1'b0; zero = 1'b0; neg = 1'b0;
        #1 chk("ill_fetch", 0, 32'(state), 32'd0);
        @(negedge clk); #1 chk("ill_decode", 0, 32'(state), 32'd1);
        @(negedge clk); #1;
        chk("ill_trap_state", 0, 32'(state), 32'd14);
        chk("ill_nt_state", 0, 32'(nt_state), 32'd0);
        chk("ill_nt_outs", 0, 32'(nt_outs), 32'(pk(1, 0, 0, 1, 0, 2, 0, 2, 0, 0, 0, 0)));
        for (int c = 0; c < 10; c++) begin
            chk("trap_state", c, 32'(state), 32'd14);
            chk("trap_outs", c, 32'(outs), 32'(pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1)));
            @(negedge clk); #1;
        end
        rst = 1'b1;
        #1 chk("trap_rst_outs", 0, 32'(outs), 32'd0);
        @(negedge clk); rst = 1'b0;
        #1;
        chk("trap_exit_state", 0, 32'(state), 32'd0);
        chk("trap_exit_outs", 0, 32'(outs), 32'(pk(1, 0, 0, 1, 0, 2, 0, 2, 0, 0, 0, 0)));

        // LUI with SUPPORT_LUI=0 traps
        do_reset();
        op = 7'(OLUI);
        @(negedge clk); @(negedge clk); #1;
        chk("lui_nl_state", 0, 32'(nl_state), 32'd14);
        chk("lui_nl_outs", 0, 32'(nl_outs), 32'(pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1)));
        chk("lui_state", 0, 32'(state), 32'd13);

        // rst while MEM_RD is waiting for memory
        do_reset();
        op = 7'(OLW); func3 = 3'd2;
        @(negedge clk); @(negedge clk);
        mem_ready = 1'b0;
        @(negedge clk); #1;
        chk("rdwait_state", 0, 32'(state), 32'd6);
        chk("rdwait_outs", 0, 32'(outs), 32'(pk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
        rst = 1'b1;
        #1 chk("rdwait_rst_outs", 0, 32'(outs), 32'd0);
        @(negedge clk); rst = 1'b0;
        #1;
        chk("rdwait_exit_state", 0, 32'(state), 32'd0);
        chk("rdwait_exit_outs", 0, 32'(outs), 32'(pk(0, 0, 0, 0, 0, 2, 0, 2, 0, 0, 0, 0)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
